// File: rtl/core_run_ctrl_pkg.sv
// Shared types for the core run controller: FSM states, error codes
// and the default halt instruction word.
package core_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EXEC,
        ST_PAUSE,
        ST_HALT,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CORE    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_e;

    localparam logic [31:0] INSN_HALT = 32'h0000_0073;

endpackage

// File: rtl/core_run_watchdog.sv
// Memory-wait watchdog: counts enabled cycles and pulses timeout
// on the cycle the count reaches the limit.
module core_run_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic cnt_en,
    output logic timeout
);

    localparam int unsigned CW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = cnt_en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: fetch / execute sequencing of the core against imem.
// Define CORE_RUN_CTRL_TIMEOUT_EN to enable the memory-wait watchdog.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_INSN      = INSN_HALT,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt_req,
    input  logic        step_mode,
    input  logic        step,
    input  logic        clear,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] core_pc,
    input  logic        core_hata,
    output logic        core_en,
    output logic [31:0] core_komut,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] retired
);

    state_e      state_q, state_d;
    err_code_e   err_code_q, err_code_d;
    logic [31:0] komut_q, komut_d;
    logic [31:0] retired_q, retired_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;
    logic        timeout;

`ifdef CORE_RUN_CTRL_TIMEOUT_EN
    logic wd_en;

    // Counter is held at zero outside FETCH/WAIT, so it restarts on entry.
    assign wd_en = (state_q == ST_FETCH) || (state_q == ST_WAIT);

    core_run_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (!wd_en),
        .cnt_en  (wd_en),
        .timeout (timeout)
    );
`else
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d    = state_q;
        komut_d    = komut_q;
        retired_d  = retired_q;
        err_code_d = err_code_q;
        if (state_q == ST_EXEC) begin
            retired_d = retired_q + 32'd1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (timeout) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end else if (imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timeout) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end else if (imem_rvalid) begin
                    komut_d = imem_rdata;
                    state_d = (imem_rdata == HALT_INSN) ? ST_HALT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (core_hata) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_CORE;
                end else if (halt_req || step_mode) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_PAUSE: begin
                if (step) begin
                    state_d = ST_FETCH;
                end else if (start && !step_mode && !halt_req) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT, ST_ERROR: begin
                if (clear) begin
                    state_d    = ST_IDLE;
                    retired_d  = '0;
                    err_code_d = ERR_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_WAIT) ||
                   (state_d == ST_EXEC);
        halted_d = (state_d == ST_HALT);
        err_d    = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            komut_q    <= '0;
            retired_q  <= '0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            komut_q    <= komut_d;
            retired_q  <= retired_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = core_pc;
    assign core_en    = (state_q == ST_EXEC);
    assign core_komut = komut_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a small imem/core responder.
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, halt_req, step_mode, step, clear;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata, core_pc, core_komut, retired;
    logic        core_hata, core_en, busy, halted, err;
    logic [1:0]  err_code;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prog [16];
    int          pidx, req_cnt, gnt_delay, en_cnt, hata_at;
    logic        rv_en, force_rv, halt_on_hata;
    int          c, t, hold;
    int          pos [4];

    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] HLT  = 32'h0000_0073;

    always #5 clk = ~clk;

    core_run_ctrl #(
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt_req    (halt_req),
        .step_mode   (step_mode),
        .step        (step),
        .clear       (clear),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .core_pc     (core_pc),
        .core_hata   (core_hata),
        .core_en     (core_en),
        .core_komut  (core_komut),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .err_code    (err_code),
        .retired     (retired)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: memory grants after gnt_delay request cycles, returns
    // data one cycle after the grant; the core bumps pc after each EXEC.
    task automatic tick();
        logic fire, en_b, req_b;
        fire  = imem_req && imem_gnt;
        en_b  = core_en;
        req_b = imem_req;
        @(posedge clk);
        #1;
        if (en_b) core_pc = core_pc + 32'd4;
        if (fire) begin
            imem_rdata = prog[pidx & 15];
            pidx++;
            req_cnt = 0;
        end else if (req_b) begin
            req_cnt++;
        end
        imem_rvalid = (fire && rv_en) || force_rv;
        imem_gnt    = imem_req && (req_cnt >= gnt_delay);
        if (core_en) en_cnt++;
        core_hata = core_en && (en_cnt == hata_at);
        halt_req  = halt_on_hata && core_hata;
    endtask

    task automatic run_count(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            if (core_en) cnt++;
        end
    endtask

    task automatic init_vars();
        start = 0; halt_req = 0; step_mode = 0; step = 0; clear = 0;
        core_pc = 32'h100; imem_gnt = 0; imem_rvalid = 0;
        imem_rdata = 0; core_hata = 0; pidx = 0; req_cnt = 0;
        gnt_delay = 0; en_cnt = 0; hata_at = 0; rv_en = 1;
        force_rv = 0; halt_on_hata = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        init_vars();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = HLT;
        for (int i = 0; i < 3; i++) prog[i] = ADDI;

        // reset state
        reset = 1;
        init_vars();
        @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_en", {31'd0, core_en}, 32'd0);
        chk("rst_komut", core_komut, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_err", {30'd0, err_code}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_addr", imem_addr, 32'h100);
        reset = 0;

        // free run to halt instruction
        tick();
        start = 1; tick(); start = 0;
        chk("fr_req", {31'd0, imem_req}, 32'd1);
        chk("fr_addr", imem_addr, 32'h100);
        c = 0;
        for (int i = 0; i < 4; i++) pos[i] = 0;
        for (int k = 2; k <= 15; k++) begin
            tick();
            if (core_en) begin
                if (c < 4) pos[c] = k;
                c++;
            end
        end
        chk("fr_en_cnt", c, 3);
        chk("fr_pos0", pos[0], 3);
        chk("fr_pos1", pos[1], 6);
        chk("fr_pos2", pos[2], 9);
        chk("fr_retired", retired, 32'd3);
        chk("fr_halted", {31'd0, halted}, 32'd1);
        chk("fr_busy", {31'd0, busy}, 32'd0);
        chk("fr_komut", core_komut, HLT);
        start = 1; tick(); start = 0;
        run_count(5, c);
        chk("halt_start_en", c, 0);
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        clear = 1; tick(); clear = 0;
        chk("clr_halted", {31'd0, halted}, 32'd0);
        chk("clr_retired", retired, 32'd0);

        // single step
        for (int i = 0; i < 16; i++) prog[i] = ADDI;
        apply_reset();
        step_mode = 1;
        start = 1; tick(); start = 0;
        run_count(8, c);
        chk("st_first_en", c, 1);
        chk("st_first_ret", retired, 32'd1);
        chk("st_pause_busy", {31'd0, busy}, 32'd0);
        for (int s = 0; s < 2; s++) begin
            step = 1; tick(); step = 0;
            run_count(7, c);
            chk("st_step_en", c, 1);
            chk("st_step_ret", retired, 32'(2 + s));
        end
        start = 1; tick(); start = 0;
        run_count(6, c);
        chk("st_start_ign", c, 0);
        step = 1; start = 1; tick(); step = 0; start = 0;
        run_count(7, c);
        chk("st_stepstart_en", c, 1);
        chk("st_stepstart_ret", retired, 32'd4);
        chk("st_stepstart_busy", {31'd0, busy}, 32'd0);

        // core error beats halt_req
        apply_reset();
        hata_at = 2;
        halt_on_hata = 1;
        start = 1; tick(); start = 0;
        run_count(12, c);
        chk("ce_en_cnt", c, 2);
        chk("ce_err", {31'd0, err}, 32'd1);
        chk("ce_code", {30'd0, err_code}, 32'd1);
        chk("ce_retired", retired, 32'd2);
        clear = 1; start = 1; tick(); clear = 0; start = 0;
        chk("ce_clr_err", {31'd0, err}, 32'd0);
        chk("ce_clr_code", {30'd0, err_code}, 32'd0);
        chk("ce_clr_ret", retired, 32'd0);
        run_count(4, c);
        chk("ce_idle_req", {31'd0, imem_req}, 32'd0);
        chk("ce_idle_en", c, 0);

        // grant withheld for 5 cycles
        apply_reset();
        core_pc = 32'h200;
        gnt_delay = 5;
        start = 1; tick(); start = 0;
        hold = 0;
        while (imem_req && hold < 20) begin
            if (imem_addr == 32'h200) hold++;
            tick();
        end
        chk("gnt_hold", hold, 6);
        chk("gnt_wait_busy", {31'd0, busy}, 32'd1);
        chk("gnt_wait_en", {31'd0, core_en}, 32'd0);
        tick();
        chk("gnt_exec_en", {31'd0, core_en}, 32'd1);

        // no read data
        apply_reset();
        rv_en = 0;
        start = 1; tick(); start = 0;
`ifdef CORE_RUN_CTRL_TIMEOUT_EN
        t = 0;
        while (!err && t < 50) begin
            tick();
            t++;
        end
        chk("to_cycles", t, 10);
        chk("to_code", {30'd0, err_code}, 32'd2);
        chk("to_req", {31'd0, imem_req}, 32'd0);
`else
        repeat (1000) tick();
        chk("nto_busy", {31'd0, busy}, 32'd1);
        chk("nto_req", {31'd0, imem_req}, 32'd0);
        chk("nto_en", {31'd0, core_en}, 32'd0);
        chk("nto_err", {31'd0, err}, 32'd0);
`endif

        // reset during WAIT with late read data
        apply_reset();
        step_mode = 1;
        start = 1; tick(); start = 0;
        run_count(6, c);
        chk("rw_komut_pre", core_komut, ADDI);
        step = 1; tick(); step = 0;
        rv_en = 0;
        tick();
        chk("rw_in_wait", {30'd0, busy, imem_req}, 32'd2);
        reset = 1;
        #1;
        chk("rw_req", {31'd0, imem_req}, 32'd0);
        chk("rw_busy", {31'd0, busy}, 32'd0);
        chk("rw_retired", retired, 32'd0);
        chk("rw_komut", core_komut, 32'd0);
        force_rv = 1;
        imem_rdata = 32'h0020_0113;
        step_mode = 0;
        tick();
        reset = 0;
        tick();
        force_rv = 0;
        tick();
        chk("rw_idle_busy", {31'd0, busy}, 32'd0);
        chk("rw_idle_komut", core_komut, 32'd0);
        chk("rw_idle_req", {31'd0, imem_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
